// File: rtl/ema_inverse.sv
// Inverse exponential moving average: recovers x[n] from the smoothed y[n] using
// a serial restoring divider (one quotient bit per cycle) and a saturating add.
module ema_inverse #(
  parameter int DATA_W  = 8,
  parameter int ALPHA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  y_i,
  input  logic [ALPHA_W-1:0] alpha_i,
  input  logic               valid_i,
  output logic [DATA_W-1:0]  x_o,
  output logic               bussy_o,
  output logic               valid_o,
  output logic               err_o
);
  localparam int DIV_W = DATA_W + ALPHA_W;
  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam int SUM_W = DIV_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept, last;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  y_prev, y_cap;
  logic [ALPHA_W-1:0] a_cap;
  logic               neg;
  logic [DIV_W-1:0]   dq;
  logic [ALPHA_W-1:0] rem;

  // cnt reaches DIV_W after the last iteration; that cycle finalizes the result
  assign last = (cnt == CNT_W'(DIV_W));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bussy_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: if (valid_i) begin
        accept    = 1'b1;
        state_nxt = DIV;
      end
      DIV: begin
        bussy_o = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (valid_i) begin
          accept    = 1'b1;
          state_nxt = DIV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  logic signed [DATA_W:0] d;
  logic        [DATA_W:0] d_mag;
  assign d     = $signed({y_i[DATA_W-1], y_i}) - $signed({y_prev[DATA_W-1], y_prev});
  assign d_mag = d[DATA_W] ? -d : d;

  // dq holds the dividend |d|<<ALPHA_W and shifts quotient bits in from the bottom
  logic [ALPHA_W:0] trial, diff;
  logic             fits;
  assign trial = {rem, dq[DIV_W-1]};
  assign diff  = trial - {1'b0, a_cap};
  assign fits  = (trial >= {1'b0, a_cap});

  logic signed [SUM_W-1:0] q_s, sum;
  logic        [DATA_W-1:0] x_nxt;
  always_comb begin
    q_s = $signed({2'b00, dq});
    if (neg) q_s = -q_s;
    sum = $signed({{(SUM_W-DATA_W){y_prev[DATA_W-1]}}, y_prev}) + q_s;
    if (sum > SAT_MAX)      x_nxt = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) x_nxt = SAT_MIN[DATA_W-1:0];
    else                    x_nxt = sum[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_prev <= '0;
      y_cap  <= '0;
      a_cap  <= '0;
      neg    <= 1'b0;
      dq     <= '0;
      rem    <= '0;
      cnt    <= '0;
      x_o    <= '0;
      err_o  <= 1'b0;
    end else if (accept) begin
      y_cap <= y_i;
      a_cap <= alpha_i;
      neg   <= d[DATA_W];
      dq    <= {d_mag[DATA_W-1:0], {ALPHA_W{1'b0}}};
      rem   <= '0;
      cnt   <= '0;
    end else if (state == DIV) begin
      if (!last) begin
        cnt <= cnt + 1'b1;
        // alpha of zero skips the divider but keeps the fixed latency
        if (a_cap != '0) begin
          dq  <= {dq[DIV_W-2:0], fits};
          rem <= fits ? diff[ALPHA_W-1:0] : trial[ALPHA_W-1:0];
        end
      end else begin
        x_o    <= (a_cap == '0) ? y_cap : x_nxt;
        err_o  <= (a_cap == '0);
        y_prev <= y_cap;
      end
    end
  end
endmodule

// File: tb/tb_ema_inverse.sv
// Directed and randomized checks of ema_inverse against an integer-arithmetic
// reference of the inverse EMA (truncating divide, saturate to 8-bit signed).
module tb_ema_inverse;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] y_i = '0;
  logic [7:0] alpha_i = '0;
  logic       valid_i = 1'b0;
  logic [7:0] x_o;
  logic       bussy_o, valid_o, err_o;

  int checks = 0;
  int errors = 0;
  int yp_m = 0;
  int last_x = 0;
  int last_err = 0;

  always #5 clk = ~clk;

  ema_inverse #(.DATA_W(8), .ALPHA_W(8)) dut (
    .clk(clk), .rst(rst), .y_i(y_i), .alpha_i(alpha_i), .valid_i(valid_i),
    .x_o(x_o), .bussy_o(bussy_o), .valid_o(valid_o), .err_o(err_o)
  );

  function automatic int model_x(int yp, int y, int a);
    int s;
    if (a == 0) return y;
    s = yp + ((y - yp) * 256) / a;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the DUT is idle or in its valid_o cycle.
  task automatic run_sample(input int y, input int a, input bit hold);
    int ex;
    y_i = 8'(y); alpha_i = 8'(a); valid_i = 1'b1;
    ex = model_x(yp_m, y, a);
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("busy_in_div", bussy_o, 1);
      check("no_early_valid", valid_o, 0);
      y_i = 8'($urandom); alpha_i = 8'($urandom); valid_i = 1'($urandom);
    end
    @(negedge clk);
    check("valid_at_17", valid_o, 1);
    check("busy_low_done", bussy_o, 0);
    check("x_out", $signed(x_o), ex);
    check("err_out", err_o, (a == 0) ? 1 : 0);
    yp_m = y; last_x = ex; last_err = (a == 0) ? 1 : 0;
    valid_i = hold;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_valid", valid_o, 0);
      check("idle_busy", bussy_o, 0);
      check("x_hold", $signed(x_o), last_x);
      check("err_hold", err_o, last_err);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    check("rst_x", $signed(x_o), 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", bussy_o, 0);
    check("rst_err", err_o, 0);
    rst = 1'b1; valid_i = 1'b0;
    yp_m = 0; last_x = 0; last_err = 0;
  endtask

  initial begin
    int y, a;
    rst = 1'b0; valid_i = 1'b1; y_i = 8'd40; alpha_i = 8'd102;
    repeat (3) @(negedge clk);
    check("init_x", $signed(x_o), 0);
    check("init_valid", valid_o, 0);
    check("init_busy", bussy_o, 0);
    check("init_err", err_o, 0);
    rst = 1'b1; valid_i = 1'b0;
    idle(2);

    run_sample(40, 102, 0);  check("basic_100", $signed(x_o), 100);
    run_sample(64, 102, 0);  check("basic_second", $signed(x_o), 100);
    run_sample(24, 102, 0);  check("neg_diff", $signed(x_o), -36);
    idle(3);
    do_reset();
    run_sample(-40, 102, 0); check("neg_result", $signed(x_o), -100);
    do_reset();
    run_sample(1, 1, 0);     check("sat_pos", $signed(x_o), 127);
    do_reset();
    run_sample(-1, 1, 0);    check("sat_neg", $signed(x_o), -128);
    run_sample(-5, 0, 0);    check("div0_x", $signed(x_o), -5);
    check("div0_err", err_o, 1);
    run_sample(10, 102, 0);  check("div0_clear", err_o, 0);
    run_sample(10, 77, 0);   check("d_zero", $signed(x_o), 10);
    idle(2);

    // back-to-back with valid_i held high
    for (int i = 0; i < 20; i++) begin
      y = int'($urandom_range(0, 255)) - 128;
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_sample(y, a, (i != 19));
    end
    idle(2);

    for (int i = 0; i < 10; i++) begin
      y = int'($urandom_range(0, 255)) - 128;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 255));
      run_sample(y, a, 0);
      idle(int'($urandom_range(0, 3)));
    end

    // abort mid-division
    y_i = 8'd40; alpha_i = 8'd102; valid_i = 1'b1;
    @(posedge clk);
    valid_i = 1'b0;
    repeat (8) @(negedge clk);
    do_reset();
    idle(20);
    run_sample(40, 102, 0);  check("after_abort", $signed(x_o), 100);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
